// File: rtl/uart_cmd_wrapper_pkg.sv
// Shared constants and state types for the UART command wrapper.
// Optional build macro: CMD_TIMEOUT_EN (inter-byte timeout in the rx path).
package cmd_pkg;

  localparam logic [7:0] RESP_ACK = 8'hA5;

  localparam logic [3:0] OP_CAL          = 4'h0;
  localparam logic [3:0] OP_MOVE         = 4'h2;
  localparam logic [3:0] OP_MOVE_FANFARE = 4'h3;
  localparam logic [3:0] OP_TOUR         = 4'h4;

  typedef enum logic {HIGH, LOW} rx_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  function automatic logic [3:0] cmd_opcode(input logic [15:0] cmd);
    return cmd[15:12];
  endfunction

endpackage

// File: rtl/uart_cmd_wrapper_if.sv
// Byte-level UART handshake and command-level processor handshake.
// master = wrapper side, slave = UART/processor side.
interface uart_cmd_wrapper_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        resp_sent;

  modport master (
    input  rx_rdy, rx_data, clr_cmd_rdy, send_resp, tx_done,
    output clr_rx_rdy, cmd, cmd_rdy, trmt, tx_data, resp_sent
  );

  modport slave (
    output rx_rdy, rx_data, clr_cmd_rdy, send_resp, tx_done,
    input  clr_rx_rdy, cmd, cmd_rdy, trmt, tx_data, resp_sent
  );
endinterface

// File: rtl/uart_cmd_wrapper_resp_sender.sv
// Transmit side: sends RESP_BYTE per send_resp, with a one-deep pending request.
module resp_sender
  import cmd_pkg::*;
#(
  parameter logic [7:0] RESP_BYTE = RESP_ACK
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send_resp,
  input  logic       tx_done,
  output logic       trmt,
  output logic [7:0] tx_data,
  output logic       resp_sent
);

  tx_state_t state;
  logic      pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= TX_IDLE;
      pending   <= 1'b0;
      trmt      <= 1'b0;
      tx_data   <= RESP_BYTE;
      resp_sent <= 1'b0;
    end else begin
      trmt      <= 1'b0;
      resp_sent <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (send_resp || pending) begin
            trmt    <= 1'b1;
            tx_data <= RESP_BYTE;
            // a new request landing while pending is served stays queued
            pending <= pending && send_resp;
            state   <= TX_BUSY;
          end
        end
        TX_BUSY: begin
          if (send_resp) pending <= 1'b1;
          if (tx_done) begin
            resp_sent <= 1'b1;
            state     <= TX_IDLE;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Pairs received UART bytes into 16-bit commands (high byte first) and returns an ack byte.
// Optional build macro: CMD_TIMEOUT_EN drops a stale high byte after TIMEOUT_CYC clocks.
module uart_cmd_wrapper
  import cmd_pkg::*;
#(
  parameter logic [7:0]  RESP_BYTE   = RESP_ACK
`ifdef CMD_TIMEOUT_EN
 ,parameter logic [23:0] TIMEOUT_CYC = 24'd2_500_000
`endif
) (
  input logic                 clk,
  input logic                 rst_n,
  uart_cmd_wrapper_if.master  bus
);

  rx_state_t  rx_state;
  logic [7:0] hi_byte;
  logic       take_hi;
  logic       take_lo;

  assign take_hi        = bus.rx_rdy && (rx_state == HIGH);
  // low byte stalls in the UART until the previous command is consumed
  assign take_lo        = bus.rx_rdy && (rx_state == LOW) && !bus.cmd_rdy;
  assign bus.clr_rx_rdy = take_hi || take_lo;

`ifdef CMD_TIMEOUT_EN
  logic [23:0] to_cnt;
  logic        timeout;
  assign timeout = (rx_state == LOW) && (to_cnt == TIMEOUT_CYC - 24'd1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state    <= HIGH;
      hi_byte     <= 8'h00;
      bus.cmd     <= 16'h0000;
      bus.cmd_rdy <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      to_cnt      <= 24'd0;
`endif
    end else begin
      if (bus.clr_cmd_rdy) bus.cmd_rdy <= 1'b0;
      case (rx_state)
        HIGH: begin
          if (take_hi) begin
            hi_byte  <= bus.rx_data;
            rx_state <= LOW;
`ifdef CMD_TIMEOUT_EN
            to_cnt   <= 24'd0;
`endif
          end
        end
        LOW: begin
          if (take_lo) begin
            bus.cmd     <= {hi_byte, bus.rx_data};
            bus.cmd_rdy <= 1'b1;
            rx_state    <= HIGH;
          end
`ifdef CMD_TIMEOUT_EN
          else if (timeout) rx_state <= HIGH;
          else              to_cnt   <= to_cnt + 24'd1;
`endif
        end
        default: rx_state <= HIGH;
      endcase
    end
  end

  resp_sender #(.RESP_BYTE(RESP_BYTE)) u_resp (
    .clk       (clk),
    .rst_n     (rst_n),
    .send_resp (bus.send_resp),
    .tx_done   (bus.tx_done),
    .trmt      (bus.trmt),
    .tx_data   (bus.tx_data),
    .resp_sent (bus.resp_sent)
  );

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed + randomized bench for uart_cmd_wrapper with a byte-stream reference model.
module tb_uart_cmd_wrapper;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   clr_cnt  = 0;

  uart_cmd_wrapper_if bus();

`ifdef CMD_TIMEOUT_EN
  uart_cmd_wrapper #(.TIMEOUT_CYC(24'd100)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
`else
  uart_cmd_wrapper dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a byte; returns taken=1 once clr_rx_rdy is seen and the edge consumes it.
  task automatic send_byte(input logic [7:0] b, input int max_wait, output bit taken);
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    taken = 1'b0;
    for (int i = 0; i < max_wait && !taken; i++) begin
      #1;
      if (bus.clr_rx_rdy) begin
        taken = 1'b1;
        clr_cnt++;
      end
      step();
    end
    if (taken) bus.rx_rdy = 1'b0;
  endtask

  task automatic clear_cmd();
    bus.clr_cmd_rdy = 1'b1;
    step();
    bus.clr_cmd_rdy = 1'b0;
  endtask

  task automatic pulse_send();
    bus.send_resp = 1'b1;
    step();
    bus.send_resp = 1'b0;
  endtask

  task automatic pulse_done();
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd"},     bus.cmd, 16'h0000);
    check({tag, "_cmd_rdy"}, bus.cmd_rdy, 1'b0);
    check({tag, "_clr_rx"},  bus.clr_rx_rdy, 1'b0);
    check({tag, "_trmt"},    bus.trmt, 1'b0);
    check({tag, "_tx_data"}, bus.tx_data, 8'hA5);
    check({tag, "_resp"},    bus.resp_sent, 1'b0);
  endtask

  // One response plus n extra requests during busy: the model says exactly one
  // more transmit follows if any request arrived, since pending is one deep.
  task automatic tx_burst(input int n, input string tag);
    int trmts;
    pulse_send();
    check({tag, "_trmt"}, bus.trmt, 1'b1);
    for (int i = 0; i < n; i++) begin
      step();
      pulse_send();
    end
    repeat ($urandom_range(2, 12)) step();
    pulse_done();
    check({tag, "_resp_sent"}, bus.resp_sent, 1'b1);
    trmts = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.trmt) trmts++;
    end
    check({tag, "_extra_trmt"}, trmts, (n > 0) ? 1 : 0);
    if (n > 0) begin
      pulse_done();
      step();
    end
  endtask

  initial begin
    bit            t;
    int            bad;
    logic [7:0]    hb, lb;
    logic [15:0]   exp_cmd;

    rst_n           = 1'b0;
    bus.rx_rdy      = 1'b0;
    bus.rx_data     = 8'h00;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b0;
    bus.tx_done     = 1'b0;
    repeat (3) step();
    check_reset_outputs("rst0");
    rst_n = 1'b1;
    step();

    // 0x20, 0x13 -> 0x2013
    clr_cnt = 0;
    send_byte(8'h20, 5, t);
    send_byte(8'h13, 5, t);
    check("t1_clr_pulses", clr_cnt, 2);
    check("t1_cmd_rdy", bus.cmd_rdy, 1'b1);
    check("t1_cmd", bus.cmd, 16'h2013);

    // cmd_rdy held: high byte consumed, low byte stalls
    send_byte(8'h40, 5, t);
    check("t2_hi_taken", t, 1'b1);
    send_byte(8'h00, 5, t);
    check("t2_lo_stalled", t, 1'b0);
    #1;
    check("t2_clr_rx_low", bus.clr_rx_rdy, 1'b0);
    check("t2_cmd_hold", bus.cmd, 16'h2013);
    clear_cmd();
    check("t2_cmd_rdy_cleared", bus.cmd_rdy, 1'b0);
    send_byte(8'h00, 5, t);
    check("t2_lo_taken", t, 1'b1);
    check("t2_cmd", bus.cmd, 16'h4000);
    check("t2_cmd_rdy", bus.cmd_rdy, 1'b1);
    clear_cmd();
    check("t2_cmd_rdy_clr", bus.cmd_rdy, 1'b0);

    // random byte pairs
    for (int k = 0; k < 8; k++) begin
      hb = 8'($urandom);
      lb = 8'($urandom);
      exp_cmd = {hb, lb};
      repeat ($urandom_range(0, 3)) step();
      send_byte(hb, 5, t);
      repeat ($urandom_range(0, 3)) step();
      send_byte(lb, 5, t);
      check("rnd_cmd", bus.cmd, exp_cmd);
      check("rnd_cmd_rdy", bus.cmd_rdy, 1'b1);
      repeat ($urandom_range(0, 4)) step();
      check("rnd_cmd_stable", bus.cmd, exp_cmd);
      clear_cmd();
    end

    // single response with a 100-cycle transmit
    pulse_send();
    check("tx_trmt", bus.trmt, 1'b1);
    check("tx_data", bus.tx_data, 8'hA5);
    step();
    check("tx_trmt_one_cycle", bus.trmt, 1'b0);
    bad = 0;
    repeat (100) begin
      step();
      if (bus.resp_sent || bus.trmt) bad++;
    end
    check("tx_quiet_busy", bad, 0);
    pulse_done();
    check("tx_resp_sent", bus.resp_sent, 1'b1);
    step();
    check("tx_resp_one_cycle", bus.resp_sent, 1'b0);

    tx_burst(2, "pend2");
    for (int k = 0; k < 4; k++) tx_burst($urandom_range(0, 3), "pend_rnd");

    // lost-byte resync
    send_byte(8'hFF, 5, t);
    repeat (150) step();
    send_byte(8'h00, 5, t);
    send_byte(8'h00, 5, t);
`ifdef CMD_TIMEOUT_EN
    check("timeout_cmd", bus.cmd, 16'h0000);
`else
    check("no_timeout_cmd", bus.cmd, 16'hFF00);
`endif
    clear_cmd();

    // reset mid-pair discards the high byte
    send_byte(8'($urandom), 5, t);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("rst_mid");
    repeat (2) step();
    rst_n = 1'b1;
    step();
    send_byte(8'h31, 5, t);
    send_byte(8'h47, 5, t);
    check("rst_cmd", bus.cmd, 16'h3147);
    check("rst_cmd_rdy", bus.cmd_rdy, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
